// File: rtl/trig_scaler.sv
// Per-channel trigger rate scaler: counts rising edges of each scal_i bit over a programmable
// gate, latches saturating counts at gate end and exposes them through a registered select mux.
module trig_scaler #(
   parameter int unsigned NCHAN      = 4,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned GATE_WIDTH = 28,
   parameter int unsigned SEL_WIDTH  = 2
) (
   input  logic                  clk250_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic [NCHAN-1:0]      scal_i,
   input  logic [GATE_WIDTH-1:0] gate_len_i,
   input  logic [SEL_WIDTH-1:0]  sel_i,
   output logic [CNT_WIDTH-1:0]  count_o,
   output logic                  ovf_o,
   output logic                  done_o
);

   typedef enum logic {StIdle, StRun} state_e;

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;

   state_e                 state_q, state_d;
   logic [NCHAN-1:0]       scal_q;
   logic [NCHAN-1:0]       edges;
   logic [GATE_WIDTH-1:0]  gate_cnt_q, gate_cnt_d;
   logic [GATE_WIDTH-1:0]  gate_last;
   logic                   count_en;
   logic                   gate_end;

   logic [CNT_WIDTH-1:0]   cnt_q     [NCHAN];
   logic [CNT_WIDTH-1:0]   cnt_d     [NCHAN];
   logic [CNT_WIDTH-1:0]   cnt_inc   [NCHAN];
   logic [CNT_WIDTH-1:0]   lat_cnt_q [NCHAN];
   logic [CNT_WIDTH-1:0]   lat_cnt_d [NCHAN];
   logic [NCHAN-1:0]       wrap;
   logic [NCHAN-1:0]       ovf_q, ovf_d;
   logic [NCHAN-1:0]       lat_ovf_q, lat_ovf_d;

   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic                   ovf_rd_q, ovf_rd_d;
   logic                   done_q;

   assign edges     = scal_i & ~scal_q;
   assign gate_last = (gate_len_i == '0) ? '0 : gate_len_i - GATE_WIDTH'(1);

   // The IDLE cycle that sees en_i high is already gate cycle 0.
   always_comb begin
      state_d  = state_q;
      count_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en_i) begin
               state_d  = StRun;
               count_en = 1'b1;
            end
         end
         StRun: begin
            if (!en_i) begin
               state_d = StIdle;
            end else begin
               count_en = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign gate_end = count_en && (gate_cnt_q >= gate_last);

   always_comb begin
      gate_cnt_d = '0;
      if (count_en && !gate_end) begin
         gate_cnt_d = gate_cnt_q + GATE_WIDTH'(1);
      end
      for (int i = 0; i < int'(NCHAN); i++) begin
         cnt_inc[i]   = cnt_q[i];
         wrap[i]      = 1'b0;
         cnt_d[i]     = '0;
         ovf_d[i]     = 1'b0;
         lat_cnt_d[i] = lat_cnt_q[i];
         lat_ovf_d[i] = lat_ovf_q[i];
         if (edges[i]) begin
            if (cnt_q[i] == CntMax) begin
               wrap[i] = 1'b1;
            end else begin
               cnt_inc[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
         end
         // Closing cycle's edge belongs to the closing gate; running state restarts at zero.
         if (gate_end) begin
            lat_cnt_d[i] = cnt_inc[i];
            lat_ovf_d[i] = ovf_q[i] | wrap[i];
         end else if (count_en) begin
            cnt_d[i] = cnt_inc[i];
            ovf_d[i] = ovf_q[i] | wrap[i];
         end
      end
   end

   always_comb begin
      count_d  = '0;
      ovf_rd_d = 1'b0;
      if (int'(sel_i) < int'(NCHAN)) begin
         count_d  = lat_cnt_q[sel_i];
         ovf_rd_d = lat_ovf_q[sel_i];
      end
   end

   always_ff @(posedge clk250_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StIdle;
         scal_q     <= '0;
         gate_cnt_q <= '0;
         ovf_q      <= '0;
         lat_ovf_q  <= '0;
         count_q    <= '0;
         ovf_rd_q   <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < int'(NCHAN); i++) begin
            cnt_q[i]     <= '0;
            lat_cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         scal_q     <= scal_i;
         gate_cnt_q <= gate_cnt_d;
         ovf_q      <= ovf_d;
         lat_ovf_q  <= lat_ovf_d;
         count_q    <= count_d;
         ovf_rd_q   <= ovf_rd_d;
         done_q     <= gate_end;
         for (int i = 0; i < int'(NCHAN); i++) begin
            cnt_q[i]     <= cnt_d[i];
            lat_cnt_q[i] <= lat_cnt_d[i];
         end
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_rd_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_trig_scaler.sv
// Directed + randomized bench for trig_scaler against an integer-count gate model.
module tb_trig_scaler;

   localparam int NCHAN = 3;
   localparam int CW    = 4;
   localparam int GW    = 28;
   localparam int SW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            en    = 1'b0;
   logic [NCHAN-1:0] scal = '0;
   logic [GW-1:0]   len   = GW'(100);
   logic [SW-1:0]   sel   = '0;
   logic [CW-1:0]   count;
   logic            ovf;
   logic            done;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: unbounded per-gate edge counts, saturated only when latched.
   logic [NCHAN-1:0] m_prev = '0;
   int   m_pos = 0;
   int   m_cnt  [NCHAN];
   int   m_lat  [NCHAN];
   bit   m_lovf [NCHAN];
   int   dcount = 0;
   int   first_done;

   trig_scaler #(
      .NCHAN      (NCHAN),
      .CNT_WIDTH  (CW),
      .GATE_WIDTH (GW),
      .SEL_WIDTH  (SW)
   ) dut (
      .clk250_i   (clk),
      .rst_n_i    (rst_n),
      .en_i       (en),
      .scal_i     (scal),
      .gate_len_i (len),
      .sel_i      (sel),
      .count_o    (count),
      .ovf_o      (ovf),
      .done_o     (done)
   );

   always #2 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = '0;
      m_pos  = 0;
      for (int i = 0; i < NCHAN; i++) begin
         m_cnt[i]  = 0;
         m_lat[i]  = 0;
         m_lovf[i] = 1'b0;
      end
   endtask

   // One clock: predict, advance, then compare all outputs.
   task automatic tick();
      logic [NCHAN-1:0] ed;
      int l;
      bit close;
      int  e_count;
      bit  e_ovf;
      ed      = scal & ~m_prev;
      close   = 1'b0;
      e_count = (int'(sel) < NCHAN) ? m_lat[sel] : 0;
      e_ovf   = (int'(sel) < NCHAN) ? m_lovf[sel] : 1'b0;
      if (!en) begin
         m_pos = 0;
         for (int i = 0; i < NCHAN; i++) m_cnt[i] = 0;
      end else begin
         for (int i = 0; i < NCHAN; i++) m_cnt[i] += int'(ed[i]);
         l = (len == 0) ? 1 : int'(len);
         if (m_pos >= l - 1) begin
            close = 1'b1;
            for (int i = 0; i < NCHAN; i++) begin
               m_lat[i]  = (m_cnt[i] > CMAX) ? CMAX : m_cnt[i];
               m_lovf[i] = (m_cnt[i] > CMAX);
               m_cnt[i]  = 0;
            end
            m_pos = 0;
         end else begin
            m_pos++;
         end
      end
      m_prev = scal;
      @(posedge clk);
      #1;
      check("done", done, close);
      check("count", count, e_count);
      check("ovf", ovf, e_ovf);
      if (done === 1'b1) dcount++;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_ovf", ovf, 0);
      check("rst_done", done, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #5;
      check("por_count", count, 0);
      check("por_ovf", ovf, 0);
      check("por_done", done, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Free-running 100-cycle gates, no edges
      en = 1'b1;
      dcount = 0;
      first_done = -1;
      for (int t = 0; t < 300; t++) begin
         tick();
         if (done === 1'b1 && first_done < 0) first_done = t;
      end
      check("s1_first_done", first_done, 99);
      check("s1_done_cnt", dcount, 3);
      check("s1_count", count, 0);

      // Spaced edges on ch0, long level on ch1
      en = 1'b0;
      tick();
      en = 1'b1;
      for (int t = 0; t < 100; t++) begin
         scal[0] = (t < 15) && (t % 3 == 0);
         scal[1] = (t >= 20) && (t < 70);
         tick();
      end
      scal = '0;
      sel  = 2'd0;
      tick();
      check("s2_ch0", count, 5);
      sel = 2'd1;
      tick();
      check("s2_ch1", count, 1);

      // Edge on the closing cycle
      en = 1'b0;
      tick();
      en = 1'b1;
      sel = 2'd0;
      for (int t = 0; t < 100; t++) begin
         scal[0] = ((t < 15) && (t % 3 == 0)) || (t == 99);
         tick();
      end
      for (int t = 0; t < 100; t++) begin
         scal[0] = (t < 20);
         tick();
         if (t == 0) check("s3_close_edge", count, 6);
      end
      tick();
      check("s3_next_gate", count, 0);

      // Saturation on ch2
      scal = '0;
      en = 1'b0;
      tick();
      en = 1'b1;
      sel = 2'd2;
      for (int t = 0; t < 100; t++) begin
         scal[2] = (t < 40) && (t % 2 == 0);
         tick();
      end
      for (int t = 0; t < 100; t++) begin
         scal[2] = (t < 6) && (t % 2 == 0);
         tick();
         if (t == 0) begin
            check("s4_sat_count", count, CMAX);
            check("s4_sat_ovf", ovf, 1);
         end
      end
      scal = '0;
      tick();
      check("s4_after_count", count, 3);
      check("s4_after_ovf", ovf, 0);
      sel = 2'd3;
      tick();
      check("s4_sel_oob", count, 0);
      sel = 2'd2;

      // Enable dropped mid-gate
      en = 1'b0;
      tick();
      en = 1'b1;
      dcount = 0;
      for (int t = 0; t < 50; t++) begin
         scal[0] = (t < 21) && (t % 3 == 0);
         tick();
      end
      en = 1'b0;
      scal = '0;
      for (int t = 0; t < 20; t++) tick();
      check("s5_no_done", dcount, 0);
      check("s5_hold_ch2", count, 3);
      en = 1'b1;
      sel = 2'd0;
      first_done = -1;
      for (int t = 0; t < 100; t++) begin
         scal[0] = (t == 10) || (t == 20);
         tick();
         if (done === 1'b1 && first_done < 0) first_done = t;
      end
      scal = '0;
      tick();
      check("s5_restart_done", first_done, 99);
      check("s5_fresh_count", count, 2);

      // Gate shortened mid-gate, zero length, reset mid-gate
      en = 1'b0;
      tick();
      en = 1'b1;
      for (int t = 0; t < 40; t++) tick();
      len = GW'(10);
      tick();
      check("s6_short_done", done, 1);
      len = '0;
      dcount = 0;
      for (int t = 0; t < 5; t++) tick();
      check("s6_len0_done", dcount, 5);
      len = GW'(100);
      for (int t = 0; t < 20; t++) begin
         scal = NCHAN'($urandom);
         tick();
      end
      pulse_reset();

      // Randomized traffic
      for (int t = 0; t < 3000; t++) begin
         en   = ($urandom_range(0, 49) != 0);
         scal = NCHAN'($urandom);
         sel  = SW'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) len = GW'($urandom_range(0, 80));
         if ($urandom_range(0, 999) == 0) pulse_reset();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
